// File: rtl/vec_pair_deserializer_pkg.sv
// Shared helpers for the pair deserializer: float/vector geometry used to place
// lane k of a packed vector.
package vec_pair_deserializer_pkg;

    function automatic int unsigned float_width(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int unsigned vec_width(input int unsigned lanes, input int unsigned fw);
        return lanes * fw;
    endfunction

    // LSB position of lane idx inside a packed vector
    function automatic int unsigned vec_lsb(input int unsigned idx, input int unsigned fw);
        return idx * fw;
    endfunction

endpackage

// File: rtl/vec_lane_buffer.sv
// Per-operand fill buffer: one write-enabled register per lane, plus the
// "merged" view (buffer with the incoming element placed and upper lanes zeroed).
module vec_lane_buffer
    import vec_pair_deserializer_pkg::*;
#(
    parameter int unsigned LANES = 7,
    parameter int unsigned FW    = 32,
    parameter int unsigned IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      lane_idx,
    input  logic [FW-1:0]         din,
    input  logic                  latch,
    input  logic                  clear,
    output logic [LANES*FW-1:0]   buf_vec,
    output logic [LANES*FW-1:0]   merged
);

    logic [LANES*FW-1:0] buf_q;
    logic [LANES*FW-1:0] buf_d;
    logic [LANES-1:0]    lane_we;

    for (genvar k = 0; k < LANES; k++) begin : g_lane_we
        assign lane_we[k] = wr_en && (lane_idx == IDX_W'(k));
    end

    always_comb begin
        merged = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (IDX_W'(k) < lane_idx) begin
                merged[vec_lsb(k, FW) +: FW] = buf_q[vec_lsb(k, FW) +: FW];
            end else if (IDX_W'(k) == lane_idx) begin
                merged[vec_lsb(k, FW) +: FW] = din;
            end
        end
    end

    always_comb begin
        buf_d = buf_q;
        if (clear) begin
            buf_d = '0;
        end else if (latch) begin
            buf_d = merged;
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (lane_we[k]) begin
                    buf_d[vec_lsb(k, FW) +: FW] = din;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign buf_vec = buf_q;

endmodule

// File: rtl/vec_pair_deserializer.sv
// Packs a stream of (lhs, rhs) float pairs into VEC_SIZE-lane vectors for vec_dot,
// with a fill buffer and an output register so input keeps flowing during stalls.
module vec_pair_deserializer
    import vec_pair_deserializer_pkg::*;
#(
    parameter int unsigned VEC_SIZE  = 7,
    parameter int unsigned EXP_WIDTH = 8,
    parameter int unsigned MAN_WIDTH = 23,
    parameter int          BIAS      = -127,
    localparam int unsigned FLOAT_WIDTH = float_width(EXP_WIDTH, MAN_WIDTH),
    localparam int unsigned VEC_WIDTH   = vec_width(VEC_SIZE, FLOAT_WIDTH),
    localparam int unsigned LEN_W       = $clog2(VEC_SIZE + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FLOAT_WIDTH-1:0] in_lhs,
    input  logic [FLOAT_WIDTH-1:0] in_rhs,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [VEC_WIDTH-1:0]   out_lhs,
    output logic [VEC_WIDTH-1:0]   out_rhs,
    output logic [LEN_W-1:0]       out_len
);

    localparam int unsigned CNT_W = $clog2(VEC_SIZE);

    // Bias only travels with the parameter set; reject nonsensical geometry early.
    if (VEC_SIZE < 2 || BIAS >= 0 || -BIAS >= (2 ** EXP_WIDTH)) begin : g_bad_params
        $error("vec_pair_deserializer: invalid parameter set");
    end

    typedef enum logic [0:0] {
        FILLING = 1'b0,
        PENDING = 1'b1
    } fill_state_t;

    fill_state_t          state_q, state_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [VEC_WIDTH-1:0] out_lhs_q, out_lhs_d;
    logic [VEC_WIDTH-1:0] out_rhs_q, out_rhs_d;
    logic [LEN_W-1:0]     out_len_q, out_len_d;

    logic                 accept, complete, slot_free;
    logic                 buf_latch, buf_clear;
    logic [VEC_WIDTH-1:0] lhs_buf, rhs_buf, lhs_merged, rhs_merged;

    assign accept    = in_valid && in_ready_q;
    assign complete  = accept && ((count_q == CNT_W'(VEC_SIZE - 1)) || in_last);
    assign slot_free = !out_valid_q || out_ready;

    vec_lane_buffer #(
        .LANES (VEC_SIZE),
        .FW    (FLOAT_WIDTH),
        .IDX_W (CNT_W)
    ) u_lhs_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept),
        .lane_idx (count_q),
        .din      (in_lhs),
        .latch    (buf_latch),
        .clear    (buf_clear),
        .buf_vec  (lhs_buf),
        .merged   (lhs_merged)
    );

    vec_lane_buffer #(
        .LANES (VEC_SIZE),
        .FW    (FLOAT_WIDTH),
        .IDX_W (CNT_W)
    ) u_rhs_buf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept),
        .lane_idx (count_q),
        .din      (in_rhs),
        .latch    (buf_latch),
        .clear    (buf_clear),
        .buf_vec  (rhs_buf),
        .merged   (rhs_merged)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        len_d       = len_q;
        out_lhs_d   = out_lhs_q;
        out_rhs_d   = out_rhs_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q && !out_ready;
        buf_latch   = 1'b0;
        buf_clear   = 1'b0;

        unique case (state_q)
            FILLING: begin
                if (complete) begin
                    count_d = '0;
                    if (slot_free) begin
                        out_lhs_d   = lhs_merged;
                        out_rhs_d   = rhs_merged;
                        out_len_d   = LEN_W'(count_q) + LEN_W'(1);
                        out_valid_d = 1'b1;
                        buf_clear   = 1'b1;
                    end else begin
                        buf_latch = 1'b1;
                        len_d     = LEN_W'(count_q) + LEN_W'(1);
                        state_d   = PENDING;
                    end
                end else if (accept) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            PENDING: begin
                if (slot_free) begin
                    out_lhs_d   = lhs_buf;
                    out_rhs_d   = rhs_buf;
                    out_len_d   = len_q;
                    out_valid_d = 1'b1;
                    buf_clear   = 1'b1;
                    count_d     = '0;
                    state_d     = FILLING;
                end
            end
            default: state_d = FILLING;
        endcase

        in_ready_d = (state_d == FILLING);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILLING;
            count_q     <= '0;
            len_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_lhs_q   <= '0;
            out_rhs_q   <= '0;
            out_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            len_q       <= len_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_lhs_q   <= out_lhs_d;
            out_rhs_q   <= out_rhs_d;
            out_len_q   <= out_len_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_lhs   = out_lhs_q;
    assign out_rhs   = out_rhs_q;
    assign out_len   = out_len_q;

endmodule
